// File: rtl/dsp_cic_dec_tdm.sv
// -----------------------------------------------------------------------------
// dsp_cic_dec_tdm
//
// Time-multiplexed CIC decimator. Channels arrive one sample per din_vld in
// round-robin order (din_ch tells which channel the next sample belongs to).
// Each channel owns N integrators and N combs (M delays each). All arithmetic
// is BOUT-bit wrap-around, which is exact for a CIC as long as BOUT covers the
// full DC gain (R_MAX*M)^N.
//
// The decimation ratio can be changed at runtime. A valid request is held as
// pending and only committed at the next channel-0 sample, so every channel in
// a frame always sees the same ratio and phase. Filter state survives a ratio
// change; only the phase counter restarts.
//
// Build option:
//   DSP_CIC_ROUND_EN  defined   : dout_cut = round-half-up of the top COUT bits,
//                                 saturated on positive overflow
//                     undefined : dout_cut = plain truncation of the top bits
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear of filter state (keeps the ratio)
//   din_vld   in   din holds a sample for channel din_ch
//   din       in   BIN-bit two's complement sample
//   rate_ld   in   single-cycle request for a new decimation ratio
//   rate      in   requested ratio, accepted when 2 <= rate <= R_MAX
//   din_ch    out  channel the next din_vld is assigned to
//   dout      out  BOUT-bit full-precision result
//   dout_cut  out  COUT-bit reduced result
//   dout_ch   out  channel of the current result
//   dvld      out  single-cycle pulse, outputs updated
// -----------------------------------------------------------------------------
module dsp_cic_dec_tdm #(
  parameter int CH       = 4,
  parameter int R_MAX    = 32,
  parameter int M        = 1,
  parameter int N        = 5,
  parameter int BIN      = 16,
  parameter int COUT     = 16,
  parameter int BOUT     = 41,
  parameter int RATE_RST = 32,
  localparam int RW      = $clog2(R_MAX + 1),
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            din_vld,
  input  logic [BIN-1:0]  din,
  input  logic            rate_ld,
  input  logic [RW-1:0]   rate,
  output logic [CW-1:0]   din_ch,
  output logic [BOUT-1:0] dout,
  output logic [COUT-1:0] dout_cut,
  output logic [CW-1:0]   dout_ch,
  output logic            dvld
);

  localparam logic [CW-1:0] CH_LAST   = CW'(CH - 1);
  localparam logic [RW-1:0] RATE_LO   = RW'(2);
  localparam logic [RW-1:0] RATE_HI   = RW'(R_MAX);
  localparam logic [RW-1:0] RATE_INIT = RW'(RATE_RST);

  // Per-channel filter state
  logic [BOUT-1:0] r_integ [CH][N];
  logic [BOUT-1:0] r_comb  [CH][N][M];

  // Sequencing and ratio control
  logic [CW-1:0]   r_din_ch;
  logic [RW-1:0]   r_phase;
  logic [RW-1:0]   r_rate_q;
  logic [RW-1:0]   r_rate_pend_val;
  logic            r_rate_pend;

  // Output registers
  logic [BOUT-1:0] r_dout;
  logic [COUT-1:0] r_dout_cut;
  logic [CW-1:0]   r_dout_ch;
  logic            r_dvld;

  logic            w_rate_ok;
  logic            w_load;
  logic            w_last_ch;
  logic            w_phase_wrap;
  logic            w_dec;
  logic [RW-1:0]   w_rate_eff;
  logic [RW-1:0]   w_phase_eff;
  logic [RW-1:0]   w_phase_nxt;
  logic [BOUT-1:0] w_din_ext;
  logic [BOUT-1:0] w_integ_nxt [N];
  logic [BOUT-1:0] w_comb_nxt  [N][M];
  logic [BOUT-1:0] w_comb_out;
  logic [COUT-1:0] w_cut;

  assign w_din_ext = {{(BOUT-BIN){din[BIN-1]}}, din};

  assign w_rate_ok = rate_ld && (rate >= RATE_LO) && (rate <= RATE_HI);
  assign w_last_ch = (r_din_ch == CH_LAST);

  // A pending ratio commits on the channel-0 sample itself: that sample is
  // already processed with the new ratio and a freshly zeroed phase.
  assign w_load      = din_vld && r_rate_pend && (r_din_ch == '0);
  assign w_rate_eff  = w_load ? r_rate_pend_val : r_rate_q;
  assign w_phase_eff = w_load ? '0 : r_phase;

  assign w_phase_wrap = (w_phase_eff == (w_rate_eff - RW'(1)));
  assign w_dec        = din_vld && w_phase_wrap;

  // Phase only advances once the whole frame (last channel) has been seen.
  always_comb begin
    w_phase_nxt = w_phase_eff;
    if (w_last_ch) begin
      if (w_phase_wrap) begin
        w_phase_nxt = '0;
      end else begin
        w_phase_nxt = w_phase_eff + RW'(1);
      end
    end
  end

  // Integrator cascade feeds forward within the same sample, then the comb
  // cascade runs on the last integrator output. Only the active channel's
  // row of state is touched.
  always_comb begin : p_datapath
    logic [BOUT-1:0] v_acc;
    v_acc = w_din_ext;
    for (int k = 0; k < N; k++) begin
      v_acc          = r_integ[r_din_ch][k] + v_acc;
      w_integ_nxt[k] = v_acc;
    end
    for (int k = 0; k < N; k++) begin
      w_comb_nxt[k][0] = v_acc;
      for (int j = 1; j < M; j++) begin
        w_comb_nxt[k][j] = r_comb[r_din_ch][k][j-1];
      end
      v_acc = v_acc - r_comb[r_din_ch][k][M-1];
    end
    w_comb_out = v_acc;
  end

`ifdef DSP_CIC_ROUND_EN
  localparam logic [COUT-1:0] CUT_MAX = {1'b0, {(COUT-1){1'b1}}};

  logic [COUT-1:0] w_trunc;
  logic            w_rbit;

  assign w_trunc = w_comb_out[BOUT-1 -: COUT];
  assign w_rbit  = w_comb_out[BOUT-COUT-1];

  // Rounding up can only overflow in the positive direction.
  assign w_cut = (w_rbit && (w_trunc == CUT_MAX)) ? CUT_MAX
                                                   : (w_trunc + COUT'(w_rbit));
`else
  assign w_cut = w_comb_out[BOUT-1 -: COUT];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_integ         <= '{default: '0};
      r_comb          <= '{default: '0};
      r_din_ch        <= '0;
      r_phase         <= '0;
      r_rate_q        <= RATE_INIT;
      r_rate_pend_val <= '0;
      r_rate_pend     <= 1'b0;
      r_dout          <= '0;
      r_dout_cut      <= '0;
      r_dout_ch       <= '0;
      r_dvld          <= 1'b0;
    end else if (clr) begin
      // Ratio is deliberately kept; any sample in this cycle is dropped.
      r_integ         <= '{default: '0};
      r_comb          <= '{default: '0};
      r_din_ch        <= '0;
      r_phase         <= '0;
      r_rate_pend     <= 1'b0;
      r_dout          <= '0;
      r_dout_cut      <= '0;
      r_dout_ch       <= '0;
      r_dvld          <= 1'b0;
    end else begin
      r_dvld <= 1'b0;

      // A new request wins over a commit in the same cycle: it becomes the
      // next pending value while the older one is consumed.
      if (w_rate_ok) begin
        r_rate_pend     <= 1'b1;
        r_rate_pend_val <= rate;
      end else if (w_load) begin
        r_rate_pend     <= 1'b0;
      end

      if (din_vld) begin
        r_integ[r_din_ch] <= w_integ_nxt;
        r_din_ch          <= w_last_ch ? '0 : (r_din_ch + CW'(1));
        r_phase           <= w_phase_nxt;
        if (w_load) begin
          r_rate_q <= r_rate_pend_val;
        end
      end

      if (w_dec) begin
        r_comb[r_din_ch] <= w_comb_nxt;
        r_dout           <= w_comb_out;
        r_dout_cut       <= w_cut;
        r_dout_ch        <= r_din_ch;
        r_dvld           <= 1'b1;
      end
    end
  end

  assign din_ch   = r_din_ch;
  assign dout     = r_dout;
  assign dout_cut = r_dout_cut;
  assign dout_ch  = r_dout_ch;
  assign dvld     = r_dvld;

endmodule

// File: tb/tb_dsp_cic_dec_tdm.sv
// -----------------------------------------------------------------------------
// tb_dsp_cic_dec_tdm
//
// Directed bench for dsp_cic_dec_tdm with default parameters (4 channels,
// R_MAX 32, N 5, M 1, 16-bit in/out, 41-bit full precision). A negedge
// monitor records the latest output, output count and output spacing per
// channel; the main sequence compares those against hand-derived values.
// -----------------------------------------------------------------------------
module tb_dsp_cic_dec_tdm;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        din_vld;
  logic [15:0] din;
  logic        rate_ld;
  logic [5:0]  rate;
  logic [1:0]  din_ch;
  logic [40:0] dout;
  logic [15:0] dout_cut;
  logic [1:0]  dout_ch;
  logic        dvld;

  int checks = 0;
  int errors = 0;

  dsp_cic_dec_tdm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .din_vld  (din_vld),
    .din      (din),
    .rate_ld  (rate_ld),
    .rate     (rate),
    .din_ch   (din_ch),
    .dout     (dout),
    .dout_cut (dout_cut),
    .dout_ch  (dout_ch),
    .dvld     (dvld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- output monitor ----------------
  int          cyc = 0;
  int          n_out  [4] = '{default: 0};
  int          gap    [4] = '{default: 0};
  int          last_t [4] = '{default: -1};
  logic [40:0] last_dout [4] = '{default: '0};
  logic [15:0] last_cut  [4] = '{default: '0};
  int          seq_err = 0;
  logic [1:0]  exp_ch = 2'd0;
  int          base_n [4] = '{default: 0};

  always @(negedge clk) begin
    if (rst_n && dvld) begin
      n_out[dout_ch]     <= n_out[dout_ch] + 1;
      last_dout[dout_ch] <= dout;
      last_cut[dout_ch]  <= dout_cut;
      if (last_t[dout_ch] >= 0) gap[dout_ch] <= cyc - last_t[dout_ch];
      last_t[dout_ch]    <= cyc;
      if (dout_ch != exp_ch) seq_err <= seq_err + 1;
      exp_ch             <= dout_ch + 2'd1;
    end
    cyc <= cyc + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) begin
      din_vld = 1'b1;
      din     = v;
      @(posedge clk); #1;
      rate_ld = 1'b0;
      clr     = 1'b0;
    end
    din_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rate_ld = 1'b0;
      clr     = 1'b0;
    end
  endtask

  task automatic snap();
    for (int c = 0; c < 4; c++) base_n[c] = n_out[c];
  endtask

  function automatic int new_outputs();
    int s = 0;
    for (int c = 0; c < 4; c++) s += n_out[c] - base_n[c];
    return s;
  endfunction

  task automatic chk_steady(input string tag, input logic signed [63:0] e_dout,
                            input logic signed [63:0] e_cut, input int e_gap,
                            input int e_cnt);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_cnt_ch%0d", tag, c), n_out[c] - base_n[c], e_cnt);
      chk($sformatf("%s_dout_ch%0d", tag, c), $signed(last_dout[c]), e_dout);
      chk($sformatf("%s_cut_ch%0d", tag, c), $signed(last_cut[c]), e_cut);
      chk($sformatf("%s_gap_ch%0d", tag, c), gap[c], e_gap);
    end
    chk($sformatf("%s_seq", tag), seq_err, 0);
  endtask

  localparam logic signed [63:0] P39 = 64'sd1 <<< 39;
  localparam logic signed [63:0] P34 = 64'sd1 <<< 34;
  localparam logic signed [63:0] P24 = 64'sd1 <<< 24;
`ifdef DSP_CIC_ROUND_EN
  localparam logic signed [63:0] CUT_R16 = 64'sd1;
`else
  localparam logic signed [63:0] CUT_R16 = 64'sd0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; clr = 1'b0; din_vld = 1'b0; din = '0; rate_ld = 1'b0; rate = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_dout", $signed(dout), 0);
    chk("rst_cut", $signed(dout_cut), 0);
    chk("rst_dvld", dvld, 0);
    chk("rst_din_ch", din_ch, 0);
    chk("rst_dout_ch", dout_ch, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // DC +16384 at rate 32: first output on the 125th sample (ch0, phase 31)
    snap();
    feed(124, 16'sd16384);
    chk("t1_no_early_out", new_outputs(), 0);
    chk("t1_din_ch_wrap", din_ch, 0);
    feed(1, 16'sd16384);
    chk("t1_first_dvld", dvld, 1);
    chk("t1_first_ch", dout_ch, 0);
    chk("t1_din_ch_inc", din_ch, 1);
    feed(3, 16'sd16384);
    chk("t1_last_ch", dout_ch, 3);
    feed(896, 16'sd16384);
    idle(3);
    chk_steady("t1", P39, 16384, 128, 8);
    chk("t1_hold_dout", $signed(dout), P39);
    chk("t1_hold_dvld", dvld, 0);

    // DC -16384
    snap();
    feed(1024, -16'sd16384);
    idle(2);
    chk_steady("t2", -P39, -16384, 128, 8);
    chk("t2_hold_dout", $signed(dout), -P39);

    // Ratio 16 requested mid-frame together with a sample; din 16
    snap();
    feed(2, 16'sd16);
    rate_ld = 1'b1; rate = 6'd16;
    feed(1, 16'sd16);
    feed(1, 16'sd16);
    feed(60, 16'sd16);
    chk("t3_no_out_before", new_outputs(), 0);
    feed(1, 16'sd16);
    chk("t3_new_rate_dvld", dvld, 1);
    chk("t3_new_rate_ch", dout_ch, 0);
    feed(3, 16'sd16);
    feed(448, 16'sd16);
    idle(2);
    chk_steady("t3", P24, CUT_R16, 64, 8);

    // Illegal ratios 0 and 300 (44 in the 6-bit port) are ignored
    snap();
    rate_ld = 1'b1; rate = 6'd0;
    feed(1, 16'sd16);
    rate_ld = 1'b1; rate = 6'(300);
    feed(1, 16'sd16);
    feed(510, 16'sd16);
    idle(2);
    chk_steady("t4", P24, CUT_R16, 64, 8);

    // clr mid-frame with a sample
    feed(2, 16'sd16);
    clr = 1'b1;
    feed(1, 16'sd16);
    chk("t5_clr_din_ch", din_ch, 0);
    chk("t5_clr_dout", $signed(dout), 0);
    chk("t5_clr_cut", $signed(dout_cut), 0);
    chk("t5_clr_dout_ch", dout_ch, 0);
    chk("t5_clr_dvld", dvld, 0);
    snap();
    feed(60, 16'sd16);
    chk("t5_no_out_before", new_outputs(), 0);
    feed(1, 16'sd16);
    chk("t5_rate_kept_dvld", dvld, 1);
    chk("t5_rate_kept_ch", dout_ch, 0);
    feed(3, 16'sd16);
    feed(448, 16'sd16);
    idle(2);
    chk_steady("t5", P24, CUT_R16, 64, 8);

    // Asynchronous reset mid-frame while running at ratio 16
    feed(2, 16'sd16);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", $signed(dout), 0);
    chk("t6_rst_cut", $signed(dout_cut), 0);
    chk("t6_rst_din_ch", din_ch, 0);
    chk("t6_rst_dout_ch", dout_ch, 0);
    chk("t6_rst_dvld", dvld, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    snap();
    feed(124, 16'sd16384);
    chk("t6_no_out_before", new_outputs(), 0);
    feed(1, 16'sd16384);
    chk("t6_first_dvld", dvld, 1);
    chk("t6_first_ch", dout_ch, 0);
    feed(3, 16'sd16384);
    feed(896, 16'sd16384);
    idle(2);
    chk_steady("t6", P39, 16384, 128, 8);

    // Second request (16) replaces the first (8) before it commits
    snap();
    feed(1, 16'sd16384);
    rate_ld = 1'b1; rate = 6'd8;
    idle(1);
    rate_ld = 1'b1; rate = 6'd16;
    feed(1, 16'sd16384);
    feed(2, 16'sd16384);
    feed(512, 16'sd16384);
    idle(2);
    chk_steady("t7", P34, 512, 64, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_cic_dec_tdm.md
DSP_CIC_DEC_TDM -- requirements
Module: dsp_cic_dec_tdm

Interface
REQ-001 SHALL have parameter CH, default 4: number of time-multiplexed channels (1..16).
REQ-002 SHALL have parameter R_MAX, default 32: maximum runtime decimation ratio (2..256).
REQ-003 SHALL have parameter M, default 1: differential delay, 1 or 2.
REQ-004 SHALL have parameter N, default 5: number of integrator and comb stages.
REQ-005 SHALL have parameter BIN, default 16: input width, two's complement.
REQ-006 SHALL have parameter COUT, default 16: width of the cut output.
REQ-007 SHALL have parameter BOUT, default 41: full-precision width, equal to BIN + ceil(N*log2(R_MAX*M)).
REQ-008 SHALL have parameter RATE_RST, default 32: rate register value after reset.
REQ-009 clk  input  1  clock; all logic on rising edge.
REQ-010 rst_n  input  1  asynchronous, active-low reset.
REQ-011 clr  input  1  synchronous clear of filter state.
REQ-012 din_vld  input  1  din holds a sample for the current channel slot.
REQ-013 din  input  BIN  input sample, two's complement.
REQ-014 rate_ld  input  1  single-cycle strobe requesting a new decimation ratio.
REQ-015 rate  input  clog2(R_MAX+1)  requested decimation ratio.
REQ-016 din_ch  output  max(1,clog2(CH))  channel index the next din_vld is assigned to.
REQ-017 dout  output  BOUT  full-precision output, two's complement.
REQ-018 dout_cut  output  COUT  reduced-width output.
REQ-019 dout_ch  output  max(1,clog2(CH))  channel index of the current output.
REQ-020 dvld  output  1  single-cycle pulse; dout, dout_cut and dout_ch are valid.

Function
REQ-021 Each din_vld SHALL be assigned to channel din_ch; din_ch SHALL increment after each din_vld and wrap from CH-1 to 0.
REQ-022 Per channel, state SHALL be N integrators and N combs of M delays each; all arithmetic SHALL be BOUT-bit wrap-around; din SHALL be sign-extended.
REQ-023 The phase counter SHALL increment after the channel CH-1 sample and wrap from rate_q-1 to 0.
REQ-024 When a sample arrives with phase == rate_q-1, that channel's integrator output SHALL enter the comb chain.
REQ-025 dvld SHALL assert exactly 1 cycle after that sample, with dout_ch = the sample's channel; there are no other dvld pulses.
REQ-026 Outputs SHALL hold their values between dvld pulses.
REQ-027 din_vld SHALL be accepted in every cycle, back-to-back, with no throughput loss.
REQ-028 rate_ld with 2 <= rate <= R_MAX SHALL set a pending flag; any other rate value SHALL be ignored.
REQ-029 The pending rate SHALL load into rate_q on the next din_vld with din_ch == 0; that load SHALL zero the phase counter, and integrator/comb state SHALL be retained.
REQ-030 A rate_ld in the same cycle as din_vld SHALL apply to that sample with the old rate_q.
REQ-031 A second rate_ld before the pending load SHALL replace the pending value.
REQ-032 clr SHALL zero the integrators, combs, din_ch, phase, pending flag and outputs; it SHALL keep rate_q.
REQ-033 clr together with din_vld SHALL drop the sample; clr wins.

Reset
REQ-034 rst_n low SHALL asynchronously zero all state, dout, dout_cut, dout_ch, dvld and din_ch, clear the pending flag, and set rate_q = RATE_RST.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; the first sample after release is channel 0.

Configuration
REQ-036 With macro DSP_CIC_ROUND_EN defined, dout_cut SHALL be dout[BOUT-1:BOUT-COUT] plus dout[BOUT-COUT-1] (round-half-up), saturated to 2^(COUT-1)-1 on positive overflow.
REQ-037 Without DSP_CIC_ROUND_EN, dout_cut SHALL be dout[BOUT-1:BOUT-COUT] (truncation) with no saturation logic.

Verification
REQ-038 Defaults, rate 32, all 4 channels din=16384 back-to-back -> from the 6th output per channel: dout=2^39, dout_cut=16384, dout_ch cycling 0,1,2,3.
REQ-039 Same setup, din=-16384 -> dout_cut=-16384 steady; dvld is one cycle per output, 32*4 cycles apart per channel.
REQ-040 rate_ld rate=16 mid-frame, din=16 -> new rate takes effect at the next channel-0 sample; steady dout=2^24; dout_cut=1 with DSP_CIC_ROUND_EN, 0 without.
REQ-041 rate_ld rate=0 and rate=300 -> ignored; output spacing unchanged.
REQ-042 clr asserted mid-frame together with din_vld -> sample dropped; din_ch=0, outputs 0, rate kept, the filter re-settles to the same steady values.
REQ-043 rst_n pulse mid-operation -> all outputs 0 immediately, rate_q=32, first post-reset output channel 0 after 32 frames.
